// File: rtl/blink_seq.sv
// blink_seq: tick-driven multi-LED pattern sequencer with load handshake,
// programmable pass count (0 = forever), pause, abort and a one-cycle done pulse.
// Optional feature macro: BLINK_SEQ_DIM_EN adds a dim port and PWM gating of led.
module blink_seq #(
  parameter int NLED    = 4,
  parameter int STEPS   = 8,
  parameter int RBITS   = 4,
  parameter int PWMBITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NLED*STEPS-1:0]   load_pattern,
  input  logic [RBITS-1:0]        load_repeat,
  input  logic                    pause,
  input  logic                    abort,
`ifdef BLINK_SEQ_DIM_EN
  input  logic [PWMBITS-1:0]      dim,
`endif
  output logic [NLED-1:0]         led,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                    busy,
  output logic                    done
);

  // PWMBITS is folded in with a zero weight so it stays referenced when
  // dimming is compiled out.
  localparam int SW = $clog2(STEPS) + 0 * PWMBITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NLED*STEPS-1:0]   pat_q, pat_d;
  logic [RBITS-1:0]        rem_q, rem_d;
  logic [SW-1:0]           step_d;
  logic [NLED-1:0]         led_d;
  logic                    busy_d;
  logic                    done_d;
  logic [NLED-1:0]         gate;

  // The handshake is only offered in IDLE and never while reset is applied.
  assign load_ready = (state_q == S_IDLE) && !rst;

`ifdef BLINK_SEQ_DIM_EN
  logic [PWMBITS-1:0] pwm_cnt;

  // Free-running dimming counter; duty = dim / 2^PWMBITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWMBITS'(1);
  end

  assign gate = {NLED{pwm_cnt < dim}};
`else
  assign gate = {NLED{1'b1}};
`endif

  // State, pattern, pass counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      rem_q   <= '0;
      step    <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      step    <= step_d;
      led     <= led_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output decode: abort beats pause, pause beats tick;
  // a tick coinciding with the load handshake is ignored.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    step_d  = step;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (load_valid) begin
          pat_d   = load_pattern;
          rem_d   = load_repeat;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (tick && !pause) begin
          if (step == SW'(STEPS - 1)) begin
            step_d = '0;
            // Zero means infinite, so it is tested before any decrement.
            if (rem_q != '0) begin
              if (rem_q == RBITS'(1)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
              rem_d = rem_q - RBITS'(1);
            end
          end else begin
            step_d = step + SW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase

    busy_d = (state_d == S_RUN);
    led_d  = '0;
    if (state_d == S_RUN)
      led_d = pat_d[step_d * NLED +: NLED] & gate;
  end

endmodule

// File: tb/tb_blink_seq.sv
// tb_blink_seq: scoreboard bench for blink_seq; expected outputs are queued
// when each cycle's stimulus is driven and popped after the clock edge.
module tb_blink_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, load_valid, load_ready, pause, abort;
  logic [31:0] load_pattern;
  logic [3:0]  load_repeat;
  logic [3:0]  led;
  logic [2:0]  step;
  logic        busy, done;
`ifdef BLINK_SEQ_DIM_EN
  logic [3:0]  dim;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] led;
    logic [2:0] step;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  blink_seq #(.NLED(4), .STEPS(8), .RBITS(4), .PWMBITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_repeat  (load_repeat),
    .pause        (pause),
    .abort        (abort),
`ifdef BLINK_SEQ_DIM_EN
    .dim          (dim),
`endif
    .led          (led),
    .step         (step),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  function automatic logic [3:0] fr(input logic [31:0] p, input int k);
    return p[k*4 +: 4];
  endfunction

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic go(input string tag, input logic t, input logic p, input logic a,
                    input logic lv, input logic [3:0] el, input logic [2:0] es,
                    input logic eb, input logic ed);
    exp_t e;
    tick = t; pause = p; abort = a; load_valid = lv;
    exp_q.push_back('{led: el, step: es, busy: eb, done: ed});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".led"},  32'(led),  32'(e.led));
    chk({tag, ".step"}, 32'(step), 32'(e.step));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa, pb, pc;
    int cnt;
    pa = 32'h8421_8421;
    pb = 32'h7654_3210;
    pc = 32'hFEDC_BA98;
    rst = 1'b1; tick = 0; load_valid = 0; pause = 0; abort = 0;
    load_pattern = '0; load_repeat = '0;
`ifdef BLINK_SEQ_DIM_EN
    dim = 4'd4;
`endif
    repeat (2) @(negedge clk);
    chk("rst.led", 32'(led), 0);
    chk("rst.step", 32'(step), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ready", 32'(load_ready), 0);
    rst = 1'b0;
    #1 chk("idle.ready", 32'(load_ready), 1);

`ifdef BLINK_SEQ_DIM_EN
    // Dimming: all-on frame, dim=4 -> lit 4 of every 16 cycles.
    load_pattern = 32'hFFFF_FFFF; load_repeat = 4'd0;
    go("dimload", 0, 0, 0, 1, led, 3'd0, 1, 0);
    load_valid = 0;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led == 4'hF) cnt++;
    end
    chk("dim4.count", 32'(cnt), 8);
    dim = 4'd0;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led != 4'h0) cnt++;
    end
    chk("dim0.count", 32'(cnt), 0);
    go("dimabort", 1, 0, 1, 0, 4'h0, 3'd0, 0, 0);
`else
    // Single pass; the tick in the load cycle is ignored.
    load_pattern = pa; load_repeat = 4'd1;
    go("sp.load", 1, 0, 0, 1, fr(pa, 0), 3'd0, 1, 0);
    go("sp.hold", 0, 0, 0, 0, fr(pa, 0), 3'd0, 1, 0);
    for (int i = 1; i < 8; i++)
      go("sp.step", 1, 0, 0, 0, fr(pa, i), 3'(i), 1, 0);
    go("sp.done", 1, 0, 0, 0, 4'h0, 3'd0, 0, 1);
    go("sp.idle", 0, 0, 0, 0, 4'h0, 3'd0, 0, 0);
    chk("sp.ready", 32'(load_ready), 1);

    // Three passes with dropped paused ticks; a new offer stays pending.
    load_pattern = pb; load_repeat = 4'd3;
    go("rp.load", 0, 0, 0, 1, fr(pb, 0), 3'd0, 1, 0);
    load_pattern = pc; load_repeat = 4'd0;
    for (int t = 1; t <= 24; t++) begin
      if (t % 5 == 0) begin
        chk("rp.ready", 32'(load_ready), 0);
        go("rp.pause", 1, 1, 0, 1, fr(pb, (t - 1) % 8), 3'((t - 1) % 8), 1, 0);
      end
      if (t < 24)
        go("rp.step", 1, 0, 0, 1, fr(pb, t % 8), 3'(t % 8), 1, 0);
      else
        go("rp.done", 1, 0, 0, 1, 4'h0, 3'd0, 0, 1);
    end
    chk("rp.ready_done", 32'(load_ready), 0);
    go("rp.idle", 0, 0, 0, 1, 4'h0, 3'd0, 0, 0);
    chk("rp.ready_idle", 32'(load_ready), 1);

    // Pending offer accepted (pause in IDLE does not block it); infinite repeat.
    go("inf.load", 0, 1, 0, 1, fr(pc, 0), 3'd0, 1, 0);
    for (int t = 1; t <= 100; t++)
      go("inf.step", 1, 0, 0, 0, fr(pc, t % 8), 3'(t % 8), 1, 0);
    chk("inf.step100", 32'(step), 4);
    go("inf.abort", 1, 0, 1, 0, 4'h0, 3'd0, 0, 0);
    go("inf.after", 0, 0, 0, 0, 4'h0, 3'd0, 0, 0);
    go("idle.abort", 0, 0, 1, 0, 4'h0, 3'd0, 0, 0);
    chk("idle.ready2", 32'(load_ready), 1);

    // Asynchronous reset in the middle of a run.
    load_pattern = pb; load_repeat = 4'd0;
    go("mr.load", 0, 0, 0, 1, fr(pb, 0), 3'd0, 1, 0);
    for (int t = 1; t <= 3; t++)
      go("mr.step", 1, 0, 0, 0, fr(pb, t), 3'(t), 1, 0);
    tick = 0;
    #2 rst = 1'b1;
    #1;
    chk("mr.led", 32'(led), 0);
    chk("mr.step", 32'(step), 0);
    chk("mr.busy", 32'(busy), 0);
    chk("mr.ready", 32'(load_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mr.ready_rel", 32'(load_ready), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_seq.md
# blink_seq

Tick-driven LED pattern sequencer downstream of the blink counter. It consumes the counter's one-cycle wrap strobe (`flg`) as its `tick` and steps through a loaded multi-LED pattern, one frame per tick. It runs for a programmed number of passes, or forever, then signals completion. New patterns arrive over a valid/ready load handshake from the control logic.

## Interface
- `NLED`, 4, number of LED outputs (frame width)
- `STEPS`, 8, frames per pattern (power of two, ≥2)
- `RBITS`, 4, width of the repeat count
- `PWMBITS`, 4, dimming counter width (used only with `BLINK_SEQ_DIM_EN`)

- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-high
- `tick`  in  1  one-cycle step strobe, from the blink counter's wrap flag
- `load_valid`  in  1  pattern offer
- `load_ready`  out  1  sequencer accepts a pattern (IDLE only)
- `load_pattern`  in  NLED*STEPS  frames; frame k = `load_pattern[k*NLED +: NLED]`
- `load_repeat`  in  RBITS  number of full passes; 0 means infinite
- `pause`  in  1  level; freezes stepping while high
- `abort`  in  1  one-cycle request to stop and return to IDLE
- `dim`  in  PWMBITS  brightness (port exists only with `BLINK_SEQ_DIM_EN`)
- `led`  out  NLED  current frame, registered
- `step`  out  clog2(STEPS)  current frame index, registered
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - **IDLE**: `load_ready` = 1, `led` = 0, `step` = 0.
  - **RUN**: outputs the current frame.
  - **DONE**: lasts 1 cycle; `done` = 1, `led` = 0; then returns to IDLE.
- **Load.** `load_valid && load_ready` in IDLE captures the pattern and repeat count, sets `step` = 0, sets passes-remaining = `load_repeat`, and enters RUN. Frame 0 appears on `led` on the next cycle.
- **Stepping.** In RUN, `tick && !pause && !abort` advances `step`.
  - At `step` == STEPS-1, `step` wraps to 0.
  - If the repeat count is nonzero, passes-remaining decrements on each wrap.
  - The wrap that ends the last pass goes to DONE instead of showing frame 0.
- **Infinite repeat.** `load_repeat` = 0 wraps forever. Only `abort` or `rst` leaves RUN.
- **Abort.** `abort` in RUN returns to IDLE on the next cycle, with `led` = 0 and no `done` pulse. `abort` is ignored in IDLE and DONE.
- **Priorities and boundary cases:**
  - `rst` > `abort` > `pause` > `tick`.
  - A `tick` in the same cycle as the load handshake is ignored; frame 0 is held for a full tick interval.
  - `load_valid` in RUN or DONE is not accepted; `load_ready` = 0. The offered pattern stays pending until IDLE.
  - `pause` high in IDLE has no effect on loading.
  - A `tick` while `pause` is high is dropped, not queued.
- **Arithmetic.** The step counter wraps modulo STEPS. Passes-remaining is RBITS wide and never underflows, because the zero check precedes the decrement.

## Timing
- **Reset values:** `led` = 0, `step` = 0, `busy` = 0, `done` = 0, state = IDLE. `load_ready` = 0 while `rst` is high.
- **Reset mid-RUN:** outputs clear immediately, asynchronously.
- **Load latency:** 1 cycle from the handshake to `busy` = 1 and `led` = frame 0.
- **Step latency:** `led` and `step` update on the cycle after the accepted `tick`.
- **Completion:** with `load_repeat` = N > 0, `done` pulses on the cycle after the (N*STEPS)-th accepted tick. `load_ready` returns 1 on the cycle after `done`.
- **Outputs:** all registered except `load_ready`, which is decoded from state and `rst`.

## Configuration
- Macro `BLINK_SEQ_DIM_EN`.
- **Defined:**
  - Adds the `dim` port and a free-running PWMBITS counter, which is cleared by `rst`.
  - `led` = frame & {NLED{pwm_cnt < dim}}, giving duty = dim/2^PWMBITS.
  - `dim` = 0 means dark. The PWM gating is registered, so latencies are unchanged.
- **Undefined:** no `dim` port and no PWM counter; `led` = frame directly.

## Test plan
- **Reset mid-run:** assert `rst` during RUN → `led` = 0, `busy` = 0, `step` = 0 immediately. After release, `load_ready` = 1.
- **Single pass:** load `load_pattern` = 32'h8421_8421, `load_repeat` = 1, then 8 ticks.
  - `led` sequence: 1,2,4,8,1,2,4,8.
  - `done` pulses 1 cycle after the 8th tick, `led` = 0, then IDLE.
- **Repeat count and pause:**
  - `load_repeat` = 3 → exactly 24 accepted ticks before `done`.
  - Ticks with `pause` = 1 are dropped and `step` holds.
- **Infinite and abort:**
  - `load_repeat` = 0 with 100 ticks → no `done`, and `step` = 100 mod 8 = 4.
  - `abort` → IDLE next cycle, `led` = 0, `done` never asserted.
- **Simultaneous events:**
  - `tick` with the load handshake → `step` stays 0.
  - `tick` + `abort` → abort wins.
  - `load_valid` during RUN → not accepted until after `done`.
- **`BLINK_SEQ_DIM_EN`, PWMBITS = 4:**
  - `dim` = 4 with frame 4'hF → `led` = 4'hF for 4 of every 16 cycles.
  - `dim` = 0 → `led` = 0.
